// File: rtl/bsg_cache_dma_rr_mux_pkg.sv
// Shared types for the cache DMA round-robin mux: send FSM states, the
// outstanding-read tag struct macro and a safe clog2 helper.

`define DECLARE_BSG_CACHE_DMA_RR_TAG_S(lg_num_dma) \
  typedef struct packed { \
    logic [lg_num_dma-1:0] id; \
    logic                  uncached; \
  } bsg_cache_dma_rr_tag_s

package bsg_cache_dma_rr_mux_pkg;

  typedef enum logic [0:0] {
    eSendIdle,
    eSendWData
  } sendState_e;

  function automatic int safeClog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_cache_dma_rr_mux_tag_fifo.sv
// Small circular FIFO holding one tag per outstanding read, in issue order.

module bsg_cache_dma_rr_mux_tag_fifo
  import bsg_cache_dma_rr_mux_pkg::*;
#(
  parameter int width_p = 2,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptrWidth = safeClog2(els_p);
  localparam int cntWidth = $clog2(els_p + 1);
  localparam logic [ptrWidth-1:0] lastSlot = ptrWidth'(els_p - 1);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptrWidth-1:0] wrPtr_q, rdPtr_q;
  logic [cntWidth-1:0] count_q;
  logic                push, pop;

  assign ready_o = (count_q != cntWidth'(els_p));
  assign v_o     = (count_q != '0);
  assign data_o  = mem_q[rdPtr_q];
  assign push    = v_i & ready_o;
  assign pop     = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wrPtr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= (wrPtr_q == lastSlot) ? '0 : wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= (rdPtr_q == lastSlot) ? '0 : rdPtr_q + 1'b1;
      count_q <= count_q + cntWidth'(push) - cntWidth'(pop);
    end
  end

endmodule

// File: rtl/bsg_cache_dma_rr_mux.sv
// Round-robin share of one cache DMA port among num_dma_p caches.
// Optional macro BSG_CACHE_DMA_RR_MUX_READ_DURING_WRITE_EN lets other caches' reads through during a write burst.

module bsg_cache_dma_rr_mux
  import bsg_cache_dma_rr_mux_pkg::*;
#(
  parameter int num_dma_p        = 2,
  parameter int dma_addr_width_p = 32,
  parameter int dma_mask_width_p = 8,
  parameter int dma_ways_p       = 8,
  parameter int dma_data_width_p = 64,
  parameter int dma_burst_len_p  = 4,
  parameter int max_reads_p      = 4,
  localparam int lg_num_dma_lp   = safeClog2(num_dma_p),
  localparam int lg_ways_lp      = safeClog2(dma_ways_p),
  localparam int dma_pkt_width_lp = 2 + lg_ways_lp + dma_mask_width_p + dma_addr_width_p
) (
  input  logic clk_i,
  input  logic reset_i,

  input  logic [num_dma_p-1:0][dma_pkt_width_lp-1:0] dma_pkt_i,
  input  logic [num_dma_p-1:0]                       dma_pkt_v_i,
  output logic [num_dma_p-1:0]                       dma_pkt_yumi_o,

  output logic [num_dma_p-1:0][dma_data_width_p-1:0] dma_data_o,
  output logic [num_dma_p-1:0]                       dma_data_v_o,
  input  logic [num_dma_p-1:0]                       dma_data_ready_and_i,

  input  logic [num_dma_p-1:0][dma_data_width_p-1:0] dma_data_i,
  input  logic [num_dma_p-1:0]                       dma_data_v_i,
  output logic [num_dma_p-1:0]                       dma_data_yumi_o,

  output logic [dma_pkt_width_lp-1:0]                dma_pkt_o,
  output logic                                       dma_pkt_v_o,
  input  logic                                       dma_pkt_yumi_i,

  input  logic [dma_data_width_p-1:0]                dma_data_i_shared,
  input  logic                                       dma_data_v_i_shared,
  output logic                                       dma_data_ready_and_o_shared,

  output logic [dma_data_width_p-1:0]                dma_data_o_shared,
  output logic                                       dma_data_v_o_shared,
  input  logic                                       dma_data_yumi_i_shared
);

  `DECLARE_BSG_CACHE_DMA_RR_TAG_S(lg_num_dma_lp);

  localparam int cntWidth = safeClog2(dma_burst_len_p);
  localparam logic [cntWidth-1:0]      burstLast = cntWidth'(dma_burst_len_p - 1);
  localparam logic [lg_num_dma_lp-1:0] lastId    = lg_num_dma_lp'(num_dma_p - 1);
  localparam logic [lg_num_dma_lp:0]   numDma    = (lg_num_dma_lp+1)'(num_dma_p);

  sendState_e                 state_q;
  logic [lg_num_dma_lp-1:0]   rrPtr_q, lockId_q;
  logic [cntWidth-1:0]        wrCnt_q, wrLast_q, rdCnt_q, rdCnt_d;

  logic [num_dma_p-1:0]       eligible;
  logic [lg_num_dma_lp-1:0]   winnerId;
  logic [lg_num_dma_lp:0]     candSum;
  logic                       found, readOk, pktFire, winWrite, winUncached;
  logic                       inWData, evictFire;
  logic                       tagReady, tagValid, tagPush, tagPop, fillFire, fillLast;
  bsg_cache_dma_rr_tag_s      tagIn, tagHead;

  // Eligibility and grant use only registered state plus the raw valids.
  always_comb begin
    eligible = '0;
    readOk   = 1'b0;
    for (int i = 0; i < num_dma_p; i++) begin
      readOk = (state_q == eSendIdle);
`ifdef BSG_CACHE_DMA_RR_MUX_READ_DURING_WRITE_EN
      readOk = readOk | (lg_num_dma_lp'(i) != lockId_q);
`endif
      if (dma_pkt_v_i[i]) begin
        if (dma_pkt_i[i][dma_pkt_width_lp-1]) eligible[i] = (state_q == eSendIdle);
        else                                  eligible[i] = readOk & tagReady;
      end
    end
  end

  always_comb begin
    winnerId = '0;
    found    = 1'b0;
    candSum  = '0;
    for (int k = 0; k < num_dma_p; k++) begin
      candSum = {1'b0, rrPtr_q} + (lg_num_dma_lp+1)'(k);
      if (candSum >= numDma) candSum = candSum - numDma;
      if (!found && eligible[candSum[lg_num_dma_lp-1:0]]) begin
        found    = 1'b1;
        winnerId = candSum[lg_num_dma_lp-1:0];
      end
    end
  end

  assign dma_pkt_o   = dma_pkt_i[winnerId];
  assign dma_pkt_v_o = found;
  assign pktFire     = dma_pkt_yumi_i & found;
  assign winWrite    = dma_pkt_o[dma_pkt_width_lp-1];
  assign winUncached = dma_pkt_o[dma_pkt_width_lp-2];
  assign inWData     = (state_q == eSendWData);
  assign evictFire   = inWData & dma_data_yumi_i_shared;

  always_comb begin
    dma_pkt_yumi_o  = '0;
    dma_data_yumi_o = '0;
    if (pktFire) dma_pkt_yumi_o[winnerId] = 1'b1;
    if (inWData) dma_data_yumi_o[lockId_q] = dma_data_yumi_i_shared;
  end

  assign dma_data_o_shared   = dma_data_i[lockId_q];
  assign dma_data_v_o_shared = inWData & dma_data_v_i[lockId_q];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= eSendIdle;
      rrPtr_q  <= '0;
      lockId_q <= '0;
      wrCnt_q  <= '0;
      wrLast_q <= '0;
    end else begin
      if (pktFire) rrPtr_q <= (winnerId == lastId) ? '0 : winnerId + 1'b1;
      case (state_q)
        eSendIdle: begin
          if (pktFire && winWrite) begin
            state_q  <= eSendWData;
            lockId_q <= winnerId;
            wrLast_q <= winUncached ? '0 : burstLast;
            wrCnt_q  <= '0;
          end
        end
        eSendWData: begin
          if (evictFire) begin
            if (wrCnt_q == wrLast_q) begin
              state_q <= eSendIdle;
              wrCnt_q <= '0;
            end else begin
              wrCnt_q <= wrCnt_q + 1'b1;
            end
          end
        end
        default: state_q <= eSendIdle;
      endcase
    end
  end

  // Receive side: the oldest outstanding read owns every returning fill beat.
  assign tagPush        = pktFire & ~winWrite;
  assign tagIn.id       = winnerId;
  assign tagIn.uncached = winUncached;

  bsg_cache_dma_rr_mux_tag_fifo #(
    .width_p ($bits(bsg_cache_dma_rr_tag_s)),
    .els_p   (max_reads_p)
  ) tagFifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (tagPush),
    .data_i  (tagIn),
    .ready_o (tagReady),
    .v_o     (tagValid),
    .data_o  (tagHead),
    .yumi_i  (tagPop)
  );

  assign dma_data_o = {num_dma_p{dma_data_i_shared}};
  assign dma_data_ready_and_o_shared = tagValid & dma_data_ready_and_i[tagHead.id];
  assign fillFire = dma_data_ready_and_o_shared & dma_data_v_i_shared;
  assign fillLast = tagHead.uncached | (rdCnt_q == burstLast);
  assign tagPop   = fillFire & fillLast;

  always_comb begin
    dma_data_v_o = '0;
    if (tagValid) dma_data_v_o[tagHead.id] = dma_data_v_i_shared;
    rdCnt_d = rdCnt_q;
    if (fillFire) rdCnt_d = fillLast ? '0 : rdCnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) rdCnt_q <= '0;
    else         rdCnt_q <= rdCnt_d;
  end

endmodule

// File: tb/tb_bsg_cache_dma_rr_mux.sv
// Directed self-checking bench for bsg_cache_dma_rr_mux (2 caches, 4-beat bursts, 4-deep tag FIFO).

module tb_bsg_cache_dma_rr_mux;

  localparam int numDma = 2;
  localparam int dataW  = 16;
  localparam int pktW   = 15;

  logic clk = 1'b0;
  logic reset;

  logic [numDma-1:0][pktW-1:0]  dmaPktI;
  logic [numDma-1:0]            dmaPktVI, dmaPktYumiO;
  logic [numDma-1:0][dataW-1:0] dmaDataO;
  logic [numDma-1:0]            dmaDataVO, dmaDataReadyI;
  logic [numDma-1:0][dataW-1:0] dmaDataI;
  logic [numDma-1:0]            dmaDataVI, dmaDataYumiO;
  logic [pktW-1:0]              pktO;
  logic                         pktVO, pktYumiI;
  logic [dataW-1:0]             sharedDataI, sharedDataO;
  logic                         sharedVI, sharedReadyO, sharedVO, sharedYumiI;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bsg_cache_dma_rr_mux #(
    .num_dma_p        (numDma),
    .dma_addr_width_p (8),
    .dma_mask_width_p (4),
    .dma_ways_p       (2),
    .dma_data_width_p (dataW),
    .dma_burst_len_p  (4),
    .max_reads_p      (4)
  ) dut (
    .clk_i                       (clk),
    .reset_i                     (reset),
    .dma_pkt_i                   (dmaPktI),
    .dma_pkt_v_i                 (dmaPktVI),
    .dma_pkt_yumi_o              (dmaPktYumiO),
    .dma_data_o                  (dmaDataO),
    .dma_data_v_o                (dmaDataVO),
    .dma_data_ready_and_i        (dmaDataReadyI),
    .dma_data_i                  (dmaDataI),
    .dma_data_v_i                (dmaDataVI),
    .dma_data_yumi_o             (dmaDataYumiO),
    .dma_pkt_o                   (pktO),
    .dma_pkt_v_o                 (pktVO),
    .dma_pkt_yumi_i              (pktYumiI),
    .dma_data_i_shared           (sharedDataI),
    .dma_data_v_i_shared         (sharedVI),
    .dma_data_ready_and_o_shared (sharedReadyO),
    .dma_data_o_shared           (sharedDataO),
    .dma_data_v_o_shared         (sharedVO),
    .dma_data_yumi_i_shared      (sharedYumiI)
  );

  // Packet layout {write_not_read, uncached_op, way_id, mask, addr}.
  function automatic logic [pktW-1:0] mkPkt(input logic wr, input logic unc, input logic [7:0] addr);
    return {wr, unc, 1'b0, 4'hF, addr};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clockEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] pktV, input logic pktYumi,
                               input logic sharedV, input logic [15:0] sharedData);
    dmaPktVI    = pktV;
    pktYumiI    = pktYumi;
    sharedVI    = sharedV;
    sharedDataI = sharedData;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    dmaPktI = '0; dmaPktVI = '0; pktYumiI = 1'b0;
    dmaDataReadyI = 2'b11; dmaDataI = '0; dmaDataVI = '0;
    sharedDataI = '0; sharedVI = 1'b0; sharedYumiI = 1'b0;
    clockEdge();
    clockEdge();
    applyStimulus(2'b00, 1'b0, 1'b0, 16'h0);
    checkOutput("rst_pkt_v", pktVO, 0);
    checkOutput("rst_pkt_yumi", dmaPktYumiO, 0);
    checkOutput("rst_fill_v", dmaDataVO, 0);
    checkOutput("rst_ready", sharedReadyO, 0);
    checkOutput("rst_evict_v", sharedVO, 0);
    checkOutput("rst_evict_yumi", dmaDataYumiO, 0);
    reset = 1'b0;
    clockEdge();

    $display("[TB] simultaneous reads from caches 0 and 1");
    dmaPktI[0] = mkPkt(1'b0, 1'b0, 8'h10);
    dmaPktI[1] = mkPkt(1'b0, 1'b0, 8'h20);
    applyStimulus(2'b11, 1'b1, 1'b0, 16'h0);
    checkOutput("rr0_v", pktVO, 1);
    checkOutput("rr0_pkt", pktO, {17'b0, mkPkt(1'b0, 1'b0, 8'h10)});
    checkOutput("rr0_yumi", dmaPktYumiO, 2'b01);
    clockEdge();
    applyStimulus(2'b11, 1'b1, 1'b0, 16'h0);
    checkOutput("rr1_pkt", pktO, {17'b0, mkPkt(1'b0, 1'b0, 8'h20)});
    checkOutput("rr1_yumi", dmaPktYumiO, 2'b10);
    clockEdge();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(2'b00, 1'b0, 1'b1, 16'h100 + 16'(k));
      checkOutput("fill_v", dmaDataVO, (k < 4) ? 2'b01 : 2'b10);
      checkOutput("fill_ready", sharedReadyO, 1);
      checkOutput("fill_data", dmaDataO[(k < 4) ? 0 : 1], 16'h100 + 16'(k));
      clockEdge();
    end
    applyStimulus(2'b00, 1'b0, 1'b1, 16'hDEAD);
    checkOutput("empty_ready", sharedReadyO, 0);
    checkOutput("empty_fill_v", dmaDataVO, 0);
    clockEdge();

    $display("[TB] fill stall on cache ready");
    applyStimulus(2'b01, 1'b1, 1'b0, 16'h0);
    checkOutput("stall_grant", dmaPktYumiO, 2'b01);
    clockEdge();
    applyStimulus(2'b00, 1'b0, 1'b1, 16'h200);
    checkOutput("stall_beat0", sharedReadyO, 1);
    clockEdge();
    dmaDataReadyI = 2'b00;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b00, 1'b0, 1'b1, 16'h201);
      checkOutput("stall_ready", sharedReadyO, 0);
      checkOutput("stall_fill_v", dmaDataVO, 2'b01);
      clockEdge();
    end
    dmaDataReadyI = 2'b11;
    for (int k = 1; k < 4; k++) begin
      applyStimulus(2'b00, 1'b0, 1'b1, 16'h200 + 16'(k));
      checkOutput("resume_ready", sharedReadyO, 1);
      checkOutput("resume_data", dmaDataO[0], 16'h200 + 16'(k));
      clockEdge();
    end
    applyStimulus(2'b00, 1'b0, 1'b1, 16'h0);
    checkOutput("stall_popped", sharedReadyO, 0);
    clockEdge();

    $display("[TB] cached write from cache 1 with cache 0 read pending");
    dmaPktI[0] = mkPkt(1'b0, 1'b0, 8'h30);
    dmaPktI[1] = mkPkt(1'b1, 1'b0, 8'h40);
    applyStimulus(2'b11, 1'b1, 1'b0, 16'h0);
    checkOutput("wr_grant", dmaPktYumiO, 2'b10);
    checkOutput("wr_pkt", pktO, {17'b0, mkPkt(1'b1, 1'b0, 8'h40)});
    clockEdge();
    dmaDataVI = 2'b11;
    dmaDataI[0] = 16'hAAAA;
    sharedYumiI = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dmaDataI[1] = 16'h300 + 16'(k);
      applyStimulus(2'b01, 1'b0, 1'b0, 16'h0);
      checkOutput("evict_v", sharedVO, 1);
      checkOutput("evict_data", sharedDataO, 16'h300 + 16'(k));
      checkOutput("evict_yumi", dmaDataYumiO, 2'b10);
`ifdef BSG_CACHE_DMA_RR_MUX_READ_DURING_WRITE_EN
      checkOutput("wdata_pkt_v", pktVO, 1);
`else
      checkOutput("wdata_pkt_v", pktVO, 0);
`endif
      clockEdge();
    end
    sharedYumiI = 1'b0;
    applyStimulus(2'b01, 1'b1, 1'b0, 16'h0);
    checkOutput("post_wr_evict_v", sharedVO, 0);
    checkOutput("post_wr_evict_yumi", dmaDataYumiO, 0);
    checkOutput("post_wr_pkt_v", pktVO, 1);
    checkOutput("post_wr_grant", dmaPktYumiO, 2'b01);
    clockEdge();
    dmaDataVI = 2'b00;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b00, 1'b0, 1'b1, 16'h400 + 16'(k));
      checkOutput("drain_fill_v", dmaDataVO, 2'b01);
      clockEdge();
    end

    $display("[TB] uncached read then uncached write");
    dmaPktI[1] = mkPkt(1'b0, 1'b1, 8'h50);
    applyStimulus(2'b10, 1'b1, 1'b0, 16'h0);
    checkOutput("unc_rd_grant", dmaPktYumiO, 2'b10);
    clockEdge();
    dmaPktI[0] = mkPkt(1'b1, 1'b1, 8'h60);
    applyStimulus(2'b01, 1'b1, 1'b1, 16'h0555);
    checkOutput("unc_wr_grant", dmaPktYumiO, 2'b01);
    checkOutput("unc_fill_v", dmaDataVO, 2'b10);
    checkOutput("unc_fill_ready", sharedReadyO, 1);
    clockEdge();
    dmaDataVI = 2'b01;
    dmaDataI[0] = 16'h0666;
    sharedYumiI = 1'b1;
    applyStimulus(2'b00, 1'b0, 1'b1, 16'h0777);
    checkOutput("unc_evict_v", sharedVO, 1);
    checkOutput("unc_evict_data", sharedDataO, 16'h0666);
    checkOutput("unc_evict_yumi", dmaDataYumiO, 2'b01);
    checkOutput("unc_tag_popped", sharedReadyO, 0);
    clockEdge();
    applyStimulus(2'b00, 1'b0, 1'b0, 16'h0);
    checkOutput("unc_one_beat_v", sharedVO, 0);
    checkOutput("unc_one_beat_yumi", dmaDataYumiO, 0);
    clockEdge();
    sharedYumiI = 1'b0;
    dmaDataVI = 2'b00;

    $display("[TB] tag FIFO full");
    dmaPktI[0] = mkPkt(1'b0, 1'b0, 8'h70);
    dmaPktI[1] = mkPkt(1'b0, 1'b0, 8'h71);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b11, 1'b1, 1'b0, 16'h0);
      checkOutput("fill_up_grant", dmaPktYumiO, (k % 2 == 0) ? 2'b10 : 2'b01);
      clockEdge();
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b11, 1'b0, 1'b1, 16'h500 + 16'(k));
      checkOutput("full_blocks", pktVO, 0);
      checkOutput("full_fill_v", dmaDataVO, 2'b10);
      clockEdge();
    end
    applyStimulus(2'b11, 1'b1, 1'b0, 16'h0);
    checkOutput("after_pop_v", pktVO, 1);
    checkOutput("after_pop_grant", dmaPktYumiO, 2'b10);
    clockEdge();

    $display("[TB] reset in the middle of a write burst");
    reset = 1'b1;
    applyStimulus(2'b00, 1'b0, 1'b0, 16'h0);
    clockEdge();
    reset = 1'b0;
    dmaPktI[0] = mkPkt(1'b1, 1'b0, 8'h80);
    applyStimulus(2'b01, 1'b1, 1'b0, 16'h0);
    checkOutput("mid_wr_grant", dmaPktYumiO, 2'b01);
    clockEdge();
    dmaDataVI = 2'b01;
    sharedYumiI = 1'b1;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(2'b00, 1'b0, 1'b0, 16'h0);
      checkOutput("mid_evict_yumi", dmaDataYumiO, 2'b01);
      clockEdge();
    end
    reset = 1'b1;
    applyStimulus(2'b00, 1'b0, 1'b1, 16'h0);
    clockEdge();
    checkOutput("rst2_evict_v", sharedVO, 0);
    checkOutput("rst2_evict_yumi", dmaDataYumiO, 0);
    checkOutput("rst2_ready", sharedReadyO, 0);
    checkOutput("rst2_fill_v", dmaDataVO, 0);
    checkOutput("rst2_pkt_v", pktVO, 0);
    reset = 1'b0;
    sharedYumiI = 1'b0;
    dmaDataVI = 2'b00;
    dmaPktI[0] = mkPkt(1'b0, 1'b0, 8'h90);
    dmaPktI[1] = mkPkt(1'b0, 1'b0, 8'h91);
    applyStimulus(2'b11, 1'b1, 1'b0, 16'h0);
    checkOutput("rst2_ptr_grant", dmaPktYumiO, 2'b01);
    checkOutput("rst2_pkt", pktO, {17'b0, mkPkt(1'b0, 1'b0, 8'h90)});
    clockEdge();
    applyStimulus(2'b00, 1'b0, 1'b0, 16'h0);
    clockEdge();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
